// File: rtl/bcd_display_arbiter_pkg.sv
// bcd_disp_pkg: shared width, FSM encoding and default dwell for the BCD display arbiter.
package bcd_disp_pkg;
  localparam int DATA_W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [31:0] DEF_DWELL = 32'd50_000_000;
endpackage

// File: rtl/bcd_display_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i with wrap.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [ID_W-1:0]  winner_o,
  output logic             valid_o
);
  always_comb begin
    winner_o = '0;
    valid_o = |req_i;
    // Walk offsets from farthest to nearest so the one closest to the pointer wins.
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_i[(int'(ptr_i) + i) % N_REQ]) winner_o = ID_W'((int'(ptr_i) + i) % N_REQ);
  end
endmodule

// File: rtl/bcd_display_arbiter.sv
// bcd_display_arbiter: round-robin sharing of one BCDDisplay, with a dwell hold-off after each update.
module bcd_display_arbiter
  import bcd_disp_pkg::*;
#(
  parameter int          N_REQ = 4,
  parameter logic [31:0] DWELL = DEF_DWELL,
  parameter int          ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic                    lockdata,
  output logic [DATA_W-1:0]       data,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);
  logic [1:0]        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d, gid_q, gid_d, win;
  logic              win_v;
  logic [DATA_W-1:0] data_q, data_d, win_data;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req_i(req),
    .ptr_i(ptr_q),
    .winner_o(win),
    .valid_o(win_v)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win == ID_W'(i)) win_data = req_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    gid_d = gid_q;
    data_d = data_q;
    if (state_q == ST_IDLE) begin
      if (win_v) begin
        state_d = ST_LOAD;
        data_d = win_data;
        gid_d = win;
        ptr_d = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      end
    end else if (state_q == ST_LOAD) begin
      state_d = ST_HOLD;
      cnt_d = '0;
    end else if (state_q == ST_HOLD) begin
      cnt_d = cnt_q + 32'd1;
      state_d = (cnt_q == DWELL - 32'd1) ? ST_IDLE : ST_HOLD;
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      ptr_q <= '0;
      gid_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    ack = '0;
    ack[gid_q] = lockdata;
  end

  assign lockdata = state_q == ST_LOAD;
  assign busy = (state_q == ST_LOAD) || (state_q == ST_HOLD);
  assign data = data_q;
  assign grant_id = gid_q;
endmodule

// File: tb/tb_bcd_display_arbiter.sv
// tb_bcd_display_arbiter: directed vector table plus hand sequences, DWELL=4, N_REQ=4.
module tb_bcd_display_arbiter;
  logic        clk = 0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] w[4];
  logic [127:0] req_data;
  logic [3:0]  ack;
  logic        lockdata;
  logic [31:0] data;
  logic [1:0]  grant_id;
  logic        busy;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        ld;
    logic [3:0]  ack;
    logic [31:0] data;
    logic [1:0]  gid;
    logic        busy;
  } vec_t;
  vec_t tbl[$];

  assign req_data = {w[3], w[2], w[1], w[0]};
  always #5 clk = ~clk;

  bcd_display_arbiter #(.N_REQ(4), .DWELL(32'd4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .lockdata(lockdata), .data(data), .grant_id(grant_id), .busy(busy)
  );

  task automatic chk(input string nm, input string f, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s.%s got=%h exp=%h", nm, f, a, e);
    end
  endtask

  task automatic step(input string nm, input logic r, input logic [3:0] rq, input logic e_ld,
                      input logic [3:0] e_ack, input logic [31:0] e_data, input logic [1:0] e_gid,
                      input logic e_busy);
    rst = r;
    req = rq;
    @(posedge clk);
    #1;
    chk(nm, "lockdata", 32'(lockdata), 32'(e_ld));
    chk(nm, "ack", 32'(ack), 32'(e_ack));
    chk(nm, "data", data, e_data);
    chk(nm, "grant_id", 32'(grant_id), 32'(e_gid));
    chk(nm, "busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic hold(input string nm, input int n, input logic [3:0] rq, input logic [31:0] d, input logic [1:0] g);
    for (int i = 0; i < n; i++) step(nm, 1'b0, rq, 1'b0, 4'b0, d, g, 1'b1);
  endtask

  function automatic void add(input logic r, input logic [3:0] rq, input logic ld, input logic [3:0] a,
                              input logic [31:0] d, input logic [1:0] g, input logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.ld = ld; v.ack = a; v.data = d; v.gid = g; v.busy = b;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1;
    req = '0;
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
    for (int i = 0; i < 3; i++) add(1, 4'hF, 0, 4'h0, 32'h0, 2'd0, 0);
    for (int k = 0; k < 5; k++) begin
      logic [1:0]  g;
      logic [31:0] d;
      g = 2'(k % 4);
      d = 32'h11 * (32'(g) + 1);
      add(0, 4'hF, 1, 4'b0001 << g, d, g, 1);
      for (int j = 0; j < 4; j++) add(0, 4'hF, 0, 4'h0, d, g, 1);
      add(0, 4'hF, 0, 4'h0, d, g, 0);
    end
    add(0, 4'h0, 0, 4'h0, 32'h11, 2'd0, 0);
    foreach (tbl[i])
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].req, tbl[i].ld, tbl[i].ack, tbl[i].data, tbl[i].gid, tbl[i].busy);

    w[2] = 32'h12345678;
    step("single_load", 0, 4'b0100, 1, 4'b0100, 32'h12345678, 2'd2, 1);
    hold("single_hold", 4, 4'b0000, 32'h12345678, 2'd2);
    step("single_idle", 0, 4'b0000, 0, 4'b0000, 32'h12345678, 2'd2, 0);

    step("wrap_load3", 0, 4'b1010, 1, 4'b1000, 32'h44, 2'd3, 1);
    hold("wrap_hold3", 4, 4'b1010, 32'h44, 2'd3);
    step("wrap_idle3", 0, 4'b1010, 0, 4'b0000, 32'h44, 2'd3, 0);
    step("wrap_load1", 0, 4'b1010, 1, 4'b0010, 32'h22, 2'd1, 1);
    hold("wrap_hold1", 4, 4'b0010, 32'h22, 2'd1);
    step("wrap_idle1", 0, 4'b0010, 0, 4'b0000, 32'h22, 2'd1, 0);
    step("skip_load1", 0, 4'b0010, 1, 4'b0010, 32'h22, 2'd1, 1);

    step("ign_hold0", 0, 4'b0000, 0, 4'b0000, 32'h22, 2'd1, 1);
    w[1] = 32'h55;
    step("ign_hold1", 0, 4'b0010, 0, 4'b0000, 32'h22, 2'd1, 1);
    step("ign_hold2", 0, 4'b0010, 0, 4'b0000, 32'h22, 2'd1, 1);
    step("ign_hold3", 0, 4'b0000, 0, 4'b0000, 32'h22, 2'd1, 1);
    step("ign_idle", 0, 4'b0000, 0, 4'b0000, 32'h22, 2'd1, 0);
    step("ign_still", 0, 4'b0000, 0, 4'b0000, 32'h22, 2'd1, 0);

    step("rsth_load", 0, 4'b0100, 1, 4'b0100, 32'h12345678, 2'd2, 1);
    step("rsth_hold0", 0, 4'b0000, 0, 4'b0000, 32'h12345678, 2'd2, 1);
    step("rsth_hold1", 0, 4'b1000, 0, 4'b0000, 32'h12345678, 2'd2, 1);
    step("rsth_hold2", 0, 4'b1000, 0, 4'b0000, 32'h12345678, 2'd2, 1);
    step("rsth_reset", 1, 4'b1000, 0, 4'b0000, 32'h0, 2'd0, 0);
    step("rsth_grant", 0, 4'b1000, 1, 4'b1000, 32'h44, 2'd3, 1);
    hold("rsth_hold", 4, 4'b0000, 32'h44, 2'd3);
    step("rsth_idle", 0, 4'b0000, 0, 4'b0000, 32'h44, 2'd3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
